ir_queue: RTL and testbench

IR_QUEUE -- requirements
Module: ir_queue

---
 rtl/lc3b_types.sv | 36 +++
 rtl/ir_decode.sv | 36 +++
 rtl/ir_queue.sv | 124 ++++++++++++
 tb/tb_ir_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b shared word, opcode, register and field types
//
// Purpose: common types used by the instruction queue and its decoder.
// Ports:   none (package).
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef logic [2:0]  lc3b_reg;
   typedef logic [10:0] lc3b_offset11;
   typedef logic [8:0]  lc3b_offset9;
   typedef logic [7:0]  lc3b_offset8;
   typedef logic [5:0]  lc3b_offset6;
   typedef logic [4:0]  lc3b_imm5;
   typedef logic [3:0]  lc3b_imm4;

endpackage

// File: rtl/ir_decode.sv
// rtl/ir_decode.sv - combinational LC-3b instruction field extractor
//
// Purpose: slices one instruction word into its decode fields.
// Ports:   word (in)   - 16-bit instruction
//          opcode, dest, src1, src2, offset11/9/8/6, imm5, imm4, ir_bits (out)
module ir_decode
   import lc3b_types::*;
(
   input  lc3b_word     word,
   output lc3b_opcode   opcode,
   output lc3b_reg      dest,
   output lc3b_reg      src1,
   output lc3b_reg      src2,
   output lc3b_offset11 offset11,
   output lc3b_offset9  offset9,
   output lc3b_offset8  offset8,
   output lc3b_offset6  offset6,
   output lc3b_imm5     imm5,
   output lc3b_imm4     imm4,
   output logic [2:0]   ir_bits
);

   assign opcode   = lc3b_opcode'(word[15:12]);
   // TRAP and JSR implicitly write the link register R7.
   assign dest     = (opcode == op_trap || opcode == op_jsr) ? 3'b111 : word[11:9];
   assign src1     = word[8:6];
   assign src2     = word[2:0];
   assign offset11 = word[10:0];
   assign offset9  = word[8:0];
   assign offset8  = word[7:0];
   assign offset6  = word[5:0];
   assign imm5     = word[4:0];
   assign imm4     = word[3:0];
   assign ir_bits  = {word[11], word[5], word[4]};

endmodule

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - instruction word FIFO with decoded head entry
//
// Purpose: buffers fetched instruction words and presents the decoded head.
//          Optional same-cycle bypass when empty: define IR_QUEUE_BYPASS_EN.
// Ports:   clk, rst (sync, active-high), flush      - control
//          in_valid, in_word, in_ready              - push side
//          out_valid, out_ready, count              - pop side / occupancy
//          opcode, dest, src1, src2, offset11/9/8/6,
//          imm5, imm4, ir_bits                      - decode of head word
module ir_queue
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  lc3b_word                 in_word,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output lc3b_opcode               opcode,
   output lc3b_reg                  dest,
   output lc3b_reg                  src1,
   output lc3b_reg                  src2,
   output lc3b_offset11             offset11,
   output lc3b_offset9              offset9,
   output lc3b_offset8              offset8,
   output lc3b_offset6              offset6,
   output lc3b_imm5                 imm5,
   output lc3b_imm4                 imm4,
   output logic [2:0]               ir_bits
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   lc3b_word          mem_q [DEPTH];
   lc3b_word          mem_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic              empty;
   logic              bypass;
   logic              push;
   logic              store;
   logic              pop_stored;
   lc3b_word          head_word;

   assign empty    = (count_q == '0);
   assign in_ready = (count_q != CW'(DEPTH));
   assign count    = count_q;

`ifdef IR_QUEUE_BYPASS_EN
   assign bypass    = empty && in_valid && !rst && !flush;
   assign head_word = !empty ? mem_q[rd_ptr_q] : (bypass ? in_word : '0);
`else
   assign bypass    = 1'b0;
   assign head_word = !empty ? mem_q[rd_ptr_q] : '0;
`endif

   assign out_valid  = !empty || bypass;
   assign push       = in_valid && in_ready;
   // A bypassed word that the consumer takes immediately never enters storage.
   assign store      = push && !(bypass && out_ready);
   assign pop_stored = !empty && out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (rst || flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (store) begin
            mem_d[wr_ptr_q] = in_word;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop_stored) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(store) - CW'(pop_stored);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; count gating keeps stale entries invisible.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   ir_decode u_decode (
      .word     (head_word),
      .opcode   (opcode),
      .dest     (dest),
      .src1     (src1),
      .src2     (src2),
      .offset11 (offset11),
      .offset9  (offset9),
      .offset8  (offset8),
      .offset6  (offset6),
      .imm5     (imm5),
      .imm4     (imm4),
      .ir_bits  (ir_bits)
   );

endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - self-checking bench for ir_queue against a queue model
module tb_ir_queue;

   localparam int DEPTH = 4;
`ifdef IR_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [15:0] in_word;
   logic        in_ready, out_valid;
   logic [2:0]  count;
   logic [3:0]  opcode;
   logic [2:0]  dest, src1, src2;
   logic [10:0] offset11;
   logic [8:0]  offset9;
   logic [7:0]  offset8;
   logic [5:0]  offset6;
   logic [4:0]  imm5;
   logic [3:0]  imm4;
   logic [2:0]  ir_bits;

   int n_cmp = 0;
   int n_mis = 0;

   logic [15:0] mq[$];
   logic [15:0] popped[$];
   bit          record = 1'b0;

   always #5 clk = ~clk;

   ir_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .count(count),
      .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
      .offset11(offset11), .offset9(offset9), .offset8(offset8), .offset6(offset6),
      .imm5(imm5), .imm4(imm4), .ir_bits(ir_bits)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit model_bypass();
      return BYP && (mq.size() == 0) && in_valid && !rst && !flush;
   endfunction

   // Drive inputs, let them settle, then compare every output to the model.
   task automatic drive(input logic r, input logic f, input logic iv,
                        input logic [15:0] w, input logic ordy);
      logic [15:0] h;
      logic [3:0]  op;
      rst = r; flush = f; in_valid = iv; in_word = w; out_ready = ordy;
      #1;
      if (mq.size() != 0)      h = mq[0];
      else if (model_bypass()) h = in_word;
      else                     h = 16'h0000;
      op = h[15:12];
      check("count",     32'(count),     32'(mq.size()));
      check("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0 || model_bypass()));
      check("opcode",    32'(opcode),    32'(op));
      check("dest",      32'(dest),      (op == 4'hF || op == 4'h4) ? 32'd7 : 32'(h[11:9]));
      check("src1",      32'(src1),      32'(h[8:6]));
      check("src2",      32'(src2),      32'(h[2:0]));
      check("offset11",  32'(offset11),  32'(h[10:0]));
      check("offset9",   32'(offset9),   32'(h[8:0]));
      check("offset8",   32'(offset8),   32'(h[7:0]));
      check("offset6",   32'(offset6),   32'(h[5:0]));
      check("imm5",      32'(imm5),      32'(h[4:0]));
      check("imm4",      32'(imm4),      32'(h[3:0]));
      check("ir_bits",   32'(ir_bits),   32'({h[11], h[5], h[4]}));
   endtask

   // Advance one clock, applying the queue rules to the model.
   task automatic tick();
      bit push, pop, byp;
      if (record && out_valid && out_ready)
         popped.push_back({opcode, ir_bits[2], offset11});
      byp  = model_bypass();
      push = in_valid && (mq.size() != DEPTH);
      pop  = (mq.size() != 0 || byp) && out_ready;
      if (rst || flush) begin
         mq.delete();
      end else if (!(byp && out_ready)) begin
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(in_word);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_check();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
   endtask

   initial begin
      int nxt;
      int cyc;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
      @(negedge clk);

      // Reset state
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
      idle_check();
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);

      // ADD word: same-cycle visibility depends on bypass, then 1-cycle latency
      drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
      check("same_cycle_ov", 32'(out_valid), 32'(BYP));
      tick();
      idle_check();
      check("add_opcode", 32'(opcode), 32'h1);
      check("add_dest", 32'(dest), 32'd1);
      check("add_src1", 32'(src1), 32'd0);
      check("add_src2", 32'(src2), 32'd4);
      check("add_imm5", 32'(imm5), 32'h14);
      check("add_ir_bits", 32'(ir_bits), 32'h3);
      check("add_count", 32'(count), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1); tick();

      // TRAP and JSR force dest to R7
      drive(1'b0, 1'b0, 1'b1, 16'hF025, 1'b0); tick();
      idle_check();
      check("trap_opcode", 32'(opcode), 32'hF);
      check("trap_dest", 32'(dest), 32'd7);
      check("trap_offset8", 32'(offset8), 32'h25);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1); tick();
      drive(1'b0, 1'b0, 1'b1, 16'h4801, 1'b0); tick();
      idle_check();
      check("jsr_dest", 32'(dest), 32'd7);
      check("jsr_offset11", 32'(offset11), 32'h001);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1); tick();

      // Fill to capacity, fifth push refused, one pop frees a slot
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0); tick();
      end
      drive(1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0);
      check("full_count", 32'(count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1); tick();
      idle_check();
      check("after_pop_count", 32'(count), 32'd3);
      check("after_pop_in_ready", 32'(in_ready), 32'd1);

      // Flush with simultaneous push and pop at count 3
      drive(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1); tick();
      idle_check();
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_opcode", 32'(opcode), 32'd0);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 16'h3000 + 16'(i), 1'b0); tick();
      end
      drive(1'b1, 1'b0, 1'b1, 16'h7777, 1'b1); tick();
      idle_check();
      check("rst_mid_count", 32'(count), 32'd0);
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_dest", 32'(dest), 32'd0);

      // Stream 10 words through with random consumer stalls
      popped.delete();
      record = 1'b1;
      nxt = 0;
      cyc = 0;
      while ((nxt < 10 || popped.size() < 10) && cyc < 300) begin
         drive(1'b0, 1'b0, nxt < 10, 16'h1000 + 16'(nxt), 1'($urandom_range(0, 1)));
         if (in_valid && mq.size() != DEPTH) nxt++;
         tick();
         cyc++;
      end
      record = 1'b0;
      check("stream_pops", 32'(popped.size()), 32'd10);
      for (int i = 0; i < 10 && i < popped.size(); i++)
         check($sformatf("stream_word%0d", i), 32'(popped[i]), 32'(16'h1000 + 16'(i)));

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         drive(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 31) == 0),
               1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
